// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers mm:ss time from a multiplexed, active-low 4-digit 7-segment
//   display bus. The select and segment lines are synchronized first.
//   Each digit dwell is then sampled exactly once, after the select has
//   been stable long enough. Four good digits form a frame. A good frame
//   is published; a bad one is counted and dropped.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   seg[6:0]    segment bus, active-low, {g,f,e,d,c,b,a}
//   select[3:0] digit enables, active-low
//               bit0 = sec ones, bit1 = sec tens, bit2 = min ones, bit3 = min tens
//   sec_ones, sec_tens, min_ones, min_tens
//               last published BCD digits
//   total_sec   last published time in seconds (0..5999)
//   frame_valid one-cycle pulse on each publish
//   time_valid  high while the published time is younger than TIMEOUT cycles
//   err_cnt     discarded-frame count, saturating at 255
//   fsm_state   debug view of the sampling FSM (0 WAIT, 1 SAMPLE, 2 HOLD)
//
// Handshake: none. The display bus is free-running, and frame_valid is a
//   pure strobe with no back-pressure. The digit outputs and total_sec
//   change only on the cycle frame_valid is high.
`timescale 1ns/1ps

module seg_scan_decoder #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  select,
   output logic [3:0]  sec_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  min_tens,
   output logic [12:0] total_sec,
   output logic        frame_valid,
   output logic        time_valid,
   output logic [7:0]  err_cnt,
   output logic [1:0]  fsm_state
);

   localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
   localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Synchronizers reset to "blank, all digits off".
   logic [6:0] seg_m, seg_s;
   logic [3:0] sel_m, sel_s, sel_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_m    <= '1;
         seg_s    <= '1;
         sel_m    <= '1;
         sel_s    <= '1;
         sel_prev <= '1;
      end else begin
         seg_m    <= seg;
         seg_s    <= seg_m;
         sel_m    <= select;
         sel_s    <= sel_m;
         sel_prev <= sel_s;
      end
   end

   logic sel_change;
   assign sel_change = (sel_s != sel_prev);

   // Dwell counter: clears on any select change, saturates at SETTLE.
   logic [7:0] cnt, cnt_next;

   always_comb begin
      cnt_next = cnt;
      if (sel_change)
         cnt_next = '0;
      else if (cnt != SETTLE_C)
         cnt_next = cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_next;
   end

   // Sampling FSM. SAMPLE is entered on the cycle the counter lands on SETTLE,
   // so a dwell yields at most one sample. HOLD waits for the next change.
   state_t state, state_next;
   logic   sample_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_WAIT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      sample_en  = 1'b0;
      case (state)
         ST_WAIT: begin
            if (cnt_next == SETTLE_C)
               state_next = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (sel_change) begin
               state_next = ST_WAIT;
            end else begin
               sample_en  = 1'b1;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (sel_change)
               state_next = ST_WAIT;
         end
         default: state_next = ST_WAIT;
      endcase
   end

   assign fsm_state = state;

   // Segment decode (active-low patterns). Blank and anything else are illegal.
   logic [3:0] digit;
   logic       digit_ok;

   always_comb begin
      digit    = '0;
      digit_ok = 1'b1;
      case (seg_s)
         7'h40: digit = 4'd0;
         7'h79: digit = 4'd1;
         7'h24: digit = 4'd2;
         7'h30: digit = 4'd3;
         7'h19: digit = 4'd4;
         7'h12: digit = 4'd5;
         7'h02: digit = 4'd6;
         7'h78: digit = 4'd7;
         7'h00: digit = 4'd8;
         7'h10: digit = 4'd9;
         default: digit_ok = 1'b0;
      endcase
   end

   // Select decode: exactly one low bit picks a position.
   logic [1:0] pos;
   logic       one_hot;
   logic       all_off;

   always_comb begin
      pos     = 2'd0;
      one_hot = 1'b1;
      case (sel_s)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: one_hot = 1'b0;
      endcase
   end

   assign all_off = (sel_s == 4'b1111);

   // Frame assembly.
   logic [3:0] shadow [4];
   logic [3:0] mask;
   logic       bad;
   logic       mask_full, publish, discard;

   assign mask_full = (mask == 4'b1111);
   assign publish   = mask_full && !bad && (shadow[1] <= 4'd5);
   assign discard   = mask_full && !publish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) shadow[i] <= '0;
         mask <= '0;
         bad  <= 1'b0;
      end else if (mask_full) begin
         mask <= '0;
         bad  <= 1'b0;
      end else if (sample_en && !all_off) begin
         if (one_hot && digit_ok) begin
            shadow[pos] <= digit;
            mask[pos]   <= 1'b1;
         end else begin
            bad <= 1'b1;
         end
      end
   end

   logic [12:0] mins_c, total_c;

   always_comb begin
      mins_c  = 13'(shadow[3]) * 13'd10 + 13'(shadow[2]);
      total_c = mins_c * 13'd60 + 13'(shadow[1]) * 13'd10 + 13'(shadow[0]);
   end

   // Published outputs, freshness tracking and error count.
   logic [23:0] idle_cnt;
   logic        seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_ones    <= '0;
         sec_tens    <= '0;
         min_ones    <= '0;
         min_tens    <= '0;
         total_sec   <= '0;
         frame_valid <= 1'b0;
         idle_cnt    <= '0;
         seen        <= 1'b0;
         err_cnt     <= '0;
      end else begin
         frame_valid <= publish;
         if (publish) begin
            sec_ones  <= shadow[0];
            sec_tens  <= shadow[1];
            min_ones  <= shadow[2];
            min_tens  <= shadow[3];
            total_sec <= total_c;
            seen      <= 1'b1;
            idle_cnt  <= '0;
         end else if (idle_cnt != TIMEOUT_C) begin
            idle_cnt <= idle_cnt + 24'd1;
         end
         if (discard && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

   assign time_valid = seen && (idle_cnt != TIMEOUT_C);

endmodule
